// File: rtl/pc_jump_sequencer_pkg.sv
// pc_pkg: shared state encoding, widths and constants for the PC sequencer
package pc_pkg;
  typedef enum logic [1:0] {RUN, STALL, FAULT} state_t;
  localparam int WORD_SHIFT = 2;
  localparam int JUMP_W = 26;
  localparam int OFF_W = 16;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/pc_jump_sequencer_target.sv
// jump_target_calc: combinational J-type and branch target generation from pc+4
module jump_target_calc
  import pc_pkg::*;
(
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [JUMP_W-1:0] jump_addr,
  input  logic [OFF_W-1:0]  branch_offset,
  output logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] branch_target
);
  logic [ADDR_W-1:0] offset_ext;
  assign offset_ext = {{(ADDR_W-OFF_W){branch_offset[OFF_W-1]}}, branch_offset};
  assign jump_target = {pc_plus4[ADDR_W-1:JUMP_W+WORD_SHIFT], jump_addr, {WORD_SHIFT{1'b0}}};
  assign branch_target = pc_plus4 + (offset_ext << WORD_SHIFT);
endmodule

// File: rtl/pc_jump_sequencer.sv
// pc_jump_sequencer: next-PC select and RUN/STALL/FAULT tracking; PC_MISALIGN_TRAP_EN enables the misaligned-JR trap
module pc_jump_sequencer
  import pc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              jump,
  input  logic [JUMP_W-1:0] jump_addr,
  input  logic              branch,
  input  logic [OFF_W-1:0]  branch_offset,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              fault_clr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              redirect,
  output logic              stalled,
  output logic              fault
);
  state_t state;
  logic [ADDR_W-1:0] jump_target, branch_target, jr_dest, next_pc;
  logic trap, non_seq;
  assign pc_plus4 = pc + 32'd4;
  jump_target_calc u_calc (
    .pc_plus4      (pc_plus4),
    .jump_addr     (jump_addr),
    .branch_offset (branch_offset),
    .jump_target   (jump_target),
    .branch_target (branch_target)
  );
`ifdef PC_MISALIGN_TRAP_EN
  assign jr_dest = jr_target;
  assign trap = jr && (jr_target[1:0] != 2'b00);
`else
  assign jr_dest = jr_target & ~32'h3;
  assign trap = 1'b0;
`endif
  assign non_seq = jr | jump | branch;
  // priority select: jr over jump over branch over sequential
  always_comb begin
    next_pc = jr ? jr_dest : jump ? jump_target : branch ? branch_target : pc_plus4;
  end
  // state machine with registered pc and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pc       <= RESET_PC;
      redirect <= 1'b0;
      stalled  <= 1'b0;
      fault    <= 1'b0;
    end else if (state == FAULT) begin
      redirect <= 1'b0;
      if (fault_clr) begin
        state <= RUN;
        fault <= 1'b0;
      end
    end else if (!en) begin
      state    <= STALL;
      stalled  <= 1'b1;
      redirect <= 1'b0;
    end else if (trap) begin
      state    <= FAULT;
      fault    <= 1'b1;
      stalled  <= 1'b0;
      redirect <= 1'b0;
    end else begin
      state    <= RUN;
      stalled  <= 1'b0;
      pc       <= next_pc;
      redirect <= non_seq;
    end
  end
endmodule

// File: tb/tb_pc_jump_sequencer.sv
// tb_pc_jump_sequencer: directed scoreboard bench for the PC sequencer
module tb_pc_jump_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, jump = 1'b0, branch = 1'b0, jr = 1'b0, fault_clr = 1'b0;
  logic [25:0] jump_addr = '0;
  logic [15:0] branch_offset = '0;
  logic [31:0] jr_target = '0;
  logic [31:0] pc, pc_plus4;
  logic        redirect, stalled, fault;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [31:0] pc;
    logic        r;
    logic        s;
    logic        f;
  } exp_t;
  exp_t sb[$];

  pc_jump_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .jump          (jump),
    .jump_addr     (jump_addr),
    .branch        (branch),
    .branch_offset (branch_offset),
    .jr            (jr),
    .jr_target     (jr_target),
    .fault_clr     (fault_clr),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .redirect      (redirect),
    .stalled       (stalled),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic compare_all(input string tag, input exp_t x);
    chk({tag, ".pc"}, pc, x.pc);
    chk({tag, ".pc_plus4"}, pc_plus4, x.pc + 32'd4);
    chk({tag, ".redirect"}, {31'b0, redirect}, {31'b0, x.r});
    chk({tag, ".stalled"}, {31'b0, stalled}, {31'b0, x.s});
    chk({tag, ".fault"}, {31'b0, fault}, {31'b0, x.f});
  endtask

  task automatic step(input string tag, input logic e, input logic j, input logic [25:0] ja,
                      input logic b, input logic [15:0] bo, input logic r, input logic [31:0] rt,
                      input logic fc, input logic [31:0] xpc, input logic xr, input logic xs,
                      input logic xf);
    exp_t x;
    en = e; jump = j; jump_addr = ja; branch = b; branch_offset = bo;
    jr = r; jr_target = rt; fault_clr = fc;
    sb.push_back('{xpc, xr, xs, xf});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      x = sb.pop_front();
      compare_all(tag, x);
    end
  endtask

  initial begin
    #12;
    compare_all("reset", '{32'h0, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;
    @(posedge clk); #1;
    //   tag        en j  jump_addr      b  offset    jr rt             fc  exp pc         r  s  f
    step("jmp_max", 1, 1, 26'h3FFFFFF, 0, 16'h0000, 0, 32'h0,         0, 32'h0FFF_FFFC, 1, 0, 0);
    step("jr_zero", 1, 0, 26'h0,       0, 16'h0000, 1, 32'h0,         0, 32'h0000_0000, 1, 0, 0);
    step("jmp_pat", 1, 1, 26'h2BCDF11, 0, 16'h0000, 0, 32'h0,         0, 32'h0AF3_7C44, 1, 0, 0);
    step("jr_100",  1, 0, 26'h0,       0, 16'h0000, 1, 32'h100,       0, 32'h0000_0100, 1, 0, 0);
    step("br_neg",  1, 0, 26'h0,       1, 16'hFFFF, 0, 32'h0,         0, 32'h0000_0100, 1, 0, 0);
    step("br_pos",  1, 0, 26'h0,       1, 16'h0010, 0, 32'h0,         0, 32'h0000_0144, 1, 0, 0);
    step("jmp_br",  1, 1, 26'h0000040, 1, 16'h0010, 0, 32'h0,         0, 32'h0000_0100, 1, 0, 0);
    step("jr_jmp",  1, 1, 26'h3FFFFFF, 1, 16'h0010, 1, 32'h0040_0000, 0, 32'h0040_0000, 1, 0, 0);
    step("seq",     1, 0, 26'h0,       0, 16'h0000, 0, 32'h0,         0, 32'h0040_0004, 0, 0, 0);
    step("jr_top",  1, 0, 26'h0,       0, 16'h0000, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 0, 0);
    step("wrap",    1, 0, 26'h0,       0, 16'h0000, 0, 32'h0,         0, 32'h0000_0000, 0, 0, 0);
    step("seq4",    1, 0, 26'h0,       0, 16'h0000, 0, 32'h0,         0, 32'h0000_0004, 0, 0, 0);
    step("stall1",  0, 1, 26'h1,       0, 16'h0000, 1, 32'h8,         0, 32'h0000_0004, 0, 1, 0);
    step("stall2",  0, 0, 26'h0,       1, 16'h0004, 0, 32'h0,         0, 32'h0000_0004, 0, 1, 0);
    step("stall3",  0, 0, 26'h0,       0, 16'h0000, 0, 32'h0,         0, 32'h0000_0004, 0, 1, 0);
`ifdef PC_MISALIGN_TRAP_EN
    step("trap",    1, 0, 26'h0,       0, 16'h0000, 1, 32'h0000_1002, 0, 32'h0000_0004, 0, 0, 1);
    step("f_hold",  1, 1, 26'h0000100, 0, 16'h0000, 0, 32'h0,         0, 32'h0000_0004, 0, 0, 1);
    step("f_clr",   1, 1, 26'h0000100, 0, 16'h0000, 0, 32'h0,         1, 32'h0000_0004, 0, 0, 0);
    step("post",    1, 0, 26'h0,       0, 16'h0000, 0, 32'h0,         0, 32'h0000_0008, 0, 0, 0);
`else
    step("jr_mis",  1, 0, 26'h0,       0, 16'h0000, 1, 32'h0000_1002, 0, 32'h0000_1000, 1, 0, 0);
    step("clr_ign", 1, 0, 26'h0,       0, 16'h0000, 0, 32'h0,         1, 32'h0000_1004, 0, 0, 0);
`endif
    step("pre_rst", 0, 0, 26'h0,       0, 16'h0000, 0, 32'h0,         0, pc,            0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    compare_all("async_rst", '{32'h0, 1'b0, 1'b0, 1'b0});
    #3;
    rst_n = 1'b1;
    en = 1'b1;
    @(posedge clk); #1;
    step("after",   1, 0, 26'h0,       0, 16'h0000, 0, 32'h0,         0, 32'h0000_0008, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
